// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment patterns are active-low, segment a on bit 0.
package seg_scan_ctrl_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam logic DP_OFF    = 1'b1;

  function automatic int cnt_width(input int slot);
    return (slot <= 2) ? 1 : $clog2(slot);
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Value load channel: hex nibbles plus decimal-point mask,
// transferred with a valid/ready handshake.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] value_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    value_valid;
  logic                    value_ready;

  modport master (
    output value_in,
    output dp_in,
    output value_valid,
    input  value_ready
  );

  modport slave (
    input  value_in,
    input  dp_in,
    input  value_valid,
    output value_ready
  );

endinterface

// File: rtl/SevenSEG.sv
// Hex nibble to active-low seven-segment pattern (a on bit 0).
// Purely combinational.
module SevenSEG
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] hex_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (hex_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed scan controller for a common-anode hex display,
// with per-slot blanking guard and frame-aligned value updates.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  lzb,
  seg_scan_ctrl_if.slave        in_if,
  output logic [NUM_DIGITS-1:0] an,
  output seg_t                  seg,
  output logic                  dp,
  output logic                  frame_tick
);

  localparam int CW = cnt_width(SLOT_CYCLES);
  localparam int DW = $clog2(NUM_DIGITS);

  typedef logic [NUM_DIGITS-1:0][3:0] nib_t;

  logic [CW-1:0]         cnt_q;
  logic [DW-1:0]         dig_q;
  logic                  full_q;
  nib_t                  sh_val_q;
  logic [NUM_DIGITS-1:0] sh_dp_q;
  nib_t                  disp_val_q;
  logic [NUM_DIGITS-1:0] disp_dp_q;
  logic [NUM_DIGITS-1:0] an_q;
  seg_t                  seg_q;
  logic                  dp_q;
  logic                  tick_q;

  logic                  last_cnt;
  logic                  last_dig;
  logic                  boundary;
  logic                  guard;
  logic                  dig_blank;
  logic                  load;
  logic [NUM_DIGITS-1:0] lz;
  logic [CW-1:0]         cnt_d;
  logic [DW-1:0]         dig_d;
  seg_t                  seg_dec;

  assign last_cnt = cnt_q == CW'(SLOT_CYCLES - 1);
  assign last_dig = dig_q == DW'(NUM_DIGITS - 1);
  assign boundary = last_cnt && last_dig;
  assign guard    = cnt_q < CW'(BLANK_CYCLES);
  assign load     = full_q && (!enable || boundary);

  assign cnt_d = last_cnt ? '0 : cnt_q + CW'(1);
  assign dig_d = !last_cnt ? dig_q
               : last_dig  ? '0
               : dig_q + DW'(1);

  // lz[k]: nibbles k..top are all zero
  always_comb begin
    lz = '0;
    lz[NUM_DIGITS-1] = disp_val_q[NUM_DIGITS-1] == 4'h0;
    for (int k = NUM_DIGITS - 2; k >= 0; k--)
      lz[k] = lz[k+1] && (disp_val_q[k] == 4'h0);
  end

  assign dig_blank = lzb && (dig_q != '0) && lz[dig_q];

  SevenSEG u_dec (
    .hex_i (disp_val_q[dig_q]),
    .seg_o (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      dig_q      <= '0;
      full_q     <= 1'b0;
      sh_val_q   <= '0;
      sh_dp_q    <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      an_q       <= '1;
      seg_q      <= SEG_BLANK;
      dp_q       <= DP_OFF;
      tick_q     <= 1'b0;
    end else begin
      if (!enable) begin
        cnt_q  <= '0;
        dig_q  <= '0;
        an_q   <= '1;
        seg_q  <= SEG_BLANK;
        dp_q   <= DP_OFF;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        dig_q  <= dig_d;
        tick_q <= boundary;
        if (guard || dig_blank) begin
          an_q  <= '1;
          seg_q <= SEG_BLANK;
          dp_q  <= DP_OFF;
        end else begin
          an_q  <= ~(NUM_DIGITS'(1) << dig_q);
          seg_q <= seg_dec;
          dp_q  <= ~disp_dp_q[dig_q];
        end
      end
      // ready is low while full, so load and capture never coincide
      if (load) begin
        disp_val_q <= sh_val_q;
        disp_dp_q  <= sh_dp_q;
        full_q     <= 1'b0;
      end else if (in_if.value_valid && !full_q) begin
        sh_val_q <= in_if.value_in;
        sh_dp_q  <= in_if.dp_in;
        full_q   <= 1'b1;
      end
    end
  end

  assign in_if.value_ready = !full_q;
  assign an                = an_q;
  assign seg               = seg_q;
  assign dp                = dp_q;
  assign frame_tick        = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-position model
// queues expected outputs, a monitor pops and compares each cycle.
module tb_seg_scan_ctrl;

  localparam int N = 4;
  localparam int S = 8;
  localparam int B = 2;
  localparam int F = N * S;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       lzb;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  seg_scan_ctrl_if #(.NUM_DIGITS(N)) vif ();

  seg_scan_ctrl #(
    .NUM_DIGITS   (N),
    .SLOT_CYCLES  (S),
    .BLANK_CYCLES (B)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .lzb        (lzb),
    .in_if      (vif),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
    logic       rdy;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] segtab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Reference model: position within the frame plus display/shadow
  int         pos = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp = '0;
  logic [15:0] sh_val = '0;
  logic [3:0]  sh_dp = '0;
  bit          sh_full = 0;

  task automatic step(input bit r, input bit e, input bit l,
                      input bit v, input logic [15:0] val,
                      input logic [3:0] d);
    exp_t       x;
    int         sl;
    int         c;
    bit         bnd;
    logic [3:0] nb;
    @(negedge clk);
    rst = r;
    enable = e;
    lzb = l;
    vif.value_valid = v;
    vif.value_in = val;
    vif.dp_in = d;
    x = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, tick: 1'b0, rdy: 1'b1};
    bnd = 0;
    if (r) begin
      pos = 0;
      m_val = '0;
      m_dp = '0;
      sh_full = 0;
    end else begin
      if (e) begin
        sl = pos / S;
        c = pos % S;
        nb = m_val[4*sl +: 4];
        if (c >= B && !(l && sl > 0 && (m_val >> (4*sl)) == 0)) begin
          x.an = ~(4'b0001 << sl);
          x.seg = segtab[nb];
          x.dp = ~m_dp[sl];
        end
        bnd = (pos == F - 1);
        x.tick = bnd;
        pos = (pos + 1) % F;
      end else begin
        pos = 0;
      end
      if (sh_full && (!e || bnd)) begin
        m_val = sh_val;
        m_dp = sh_dp;
        sh_full = 0;
      end else if (v && !sh_full) begin
        sh_val = val;
        sh_dp = d;
        sh_full = 1;
      end
    end
    x.rdy = !sh_full;
    expq.push_back(x);
  endtask

  task automatic run(input int n, input bit e, input bit l);
    for (int i = 0; i < n; i++)
      step(0, e, l, 0, 16'($urandom), 4'($urandom));
  endtask

  // Hold valid until the model shows the value was taken
  task automatic offer(input logic [15:0] val, input logic [3:0] d,
                       input bit e, input bit l);
    bit was;
    bit done;
    done = 0;
    for (int i = 0; i < 4 * F && !done; i++) begin
      was = sh_full;
      step(0, e, l, 1, val, d);
      if (!was) done = 1;
    end
    if (!done) begin
      errors++;
      $display("FAIL offer: value %h not accepted in budget", val);
    end
  endtask

  exp_t got;
  exp_t want;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (expq.size() > 0) begin
        want = expq.pop_front();
        got = {an, seg, dp, frame_tick, vif.value_ready};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL outputs @%0t: got an=%h seg=%h dp=%b tick=%b rdy=%b, want an=%h seg=%h dp=%b tick=%b rdy=%b",
                   $time, got.an, got.seg, got.dp, got.tick, got.rdy,
                   want.an, want.seg, want.dp, want.tick, want.rdy);
        end
      end
    end
  end

  initial begin
    bit en_r;
    bit lz_r;
    int guard_n;
    rst = 1'b1;
    enable = 1'b0;
    lzb = 1'b0;
    vif.value_valid = 1'b0;
    vif.value_in = '0;
    vif.dp_in = '0;

    repeat (3) step(1, 0, 0, 1, 16'hBEEF, 4'hF);
    run(1, 0, 0);

    offer(16'h12AF, 4'b0010, 1, 0);
    run(3 * F, 1, 0);

    offer(16'h0030, 4'b0000, 1, 1);
    run(3 * F, 1, 1);
    run(2 * F, 1, 0);

    offer(16'h4567, 4'b0101, 1, 0);
    offer(16'h89CD, 4'b1010, 1, 0);
    run(3 * F, 1, 0);

    guard_n = 0;
    while (pos != 2 * S + 4 && guard_n < 2 * F) begin
      run(1, 1, 0);
      guard_n++;
    end
    run(5, 0, 0);
    run(2 * F, 1, 0);

    en_r = 1;
    lz_r = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(199) == 0) lz_r = !lz_r;
      if ($urandom_range(299) == 0) en_r = 0;
      else if (!en_r && $urandom_range(7) == 0) en_r = 1;
      if ($urandom_range(999) == 0)
        step(1, en_r, lz_r, 1, 16'($urandom), 4'($urandom));
      else
        step(0, en_r, lz_r, ($urandom_range(3) == 0),
             ($urandom_range(3) == 0) ? 16'($urandom_range(255))
                                      : 16'($urandom),
             4'($urandom));
    end

    @(posedge clk);
    #3;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked",
               expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
